// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// A byte moves on a rising edge where byte_valid && byte_ready; byte_data and byte_last are only meaningful while byte_valid is high. The host must not wait for byte_ready before raising byte_valid. The memory side has no backpressure: imem_we is a one-cycle strobe.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data, byte_last,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data, byte_last,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: packs a big-endian byte stream into 32-bit words written to imem from address 0 while holding the core.
// Optional trailing XOR checksum byte is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_reg;
  logic              last_q;
  logic              error_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              xfer;
  logic              err_set;
  logic              clear_load;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
  logic              csum_byte;
  // A byte flagged last at a word boundary is the checksum, not data.
  assign csum_byte = (byte_cnt == 2'd0) && bus.byte_last;
`endif

  assign xfer       = bus.byte_valid && (state == S_LOAD);
  assign clear_load = (state == S_IDLE) || ((state == S_DONE) && start);

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (csum_byte) begin
            state_next = S_DONE;
            err_set    = (bus.byte_data != csum);
          end else
`endif
          if (byte_cnt == 2'd3) begin
            state_next = S_WRITE;
          end else if (bus.byte_last) begin
            state_next = S_DONE;
            err_set    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (last_q) begin
          state_next = S_DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          err_set    = 1'b1;
`endif
        end else if (addr == '1) begin
          state_next = S_DONE;
          err_set    = 1'b1;
        end else begin
          state_next = S_LOAD;
        end
      end
      S_DONE: if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      addr         <= '0;
      byte_cnt     <= 2'd0;
      word_reg     <= '0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count   <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state <= state_next;
      if (clear_load) begin
        addr       <= '0;
        byte_cnt   <= 2'd0;
        last_q     <= 1'b0;
        error_q    <= 1'b0;
        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= 8'd0;
`endif
      end
      if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!csum_byte) csum <= csum ^ bus.byte_data;
`endif
        word_reg <= {word_reg[15:0], bus.byte_data};
        byte_cnt <= byte_cnt + 2'd1;
        // Memory-side registers only move when a word is complete, so they hold outside WRITE.
        if (byte_cnt == 2'd3) begin
          imem_wdata_q <= {word_reg, bus.byte_data};
          imem_addr_q  <= addr;
          last_q       <= bus.byte_last;
        end
      end
      if (state == S_WRITE) begin
        addr       <= addr + ADDR_ONE;
        word_count <= word_count + COUNT_ONE;
        last_q     <= 1'b0;
      end
      if (err_set) error_q <= 1'b1;
    end
  end

  assign bus.byte_ready = (state == S_LOAD);
  assign bus.imem_we    = (state == S_WRITE);
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_hold       = (state == S_LOAD) || (state == S_WRITE);
  assign done           = (state == S_DONE);
  assign error          = error_q;
  assign state_dbg      = state;

endmodule
